// File: rtl/input_conditioner_if.sv
// Signal bundle between a raw asynchronous input source and its conditioner.
// The master drives the raw input; the slave returns the cleaned level and strobes.
interface input_conditioner_if;
  logic       async_i;
  logic       level_o;
  logic       rise_o;
  logic       fall_o;
  logic [7:0] glitch_cnt_o;

  modport master (
    output async_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  glitch_cnt_o
  );

  modport slave (
    input  async_i,
    output level_o,
    output rise_o,
    output fall_o,
    output glitch_cnt_o
  );
endinterface

// File: rtl/input_conditioner.sv
// Turns a raw asynchronous, possibly bouncing input into a debounced clk-synchronous
// level with single-cycle rise/fall strobes and a saturating count of rejected glitches.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input_conditioner_if.slave bus
);

  // state     | meaning
  // STABLE_LO | output low, synchronized input agrees
  // CHK_HI    | output low, input high, counting qualifying samples
  // STABLE_HI | output high, synchronized input agrees
  // CHK_LO    | output high, input low, counting qualifying samples
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          glitch_inc;
  logic          level_d;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic [7:0]    glitch_q;

  // Plain shift chain: nothing may sit between the metastability-settling stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.async_i};
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    glitch_inc = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HI;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!sync_q) begin
          state_d    = STABLE_LO;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LO;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (sync_q) begin
          state_d    = STABLE_HI;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Level and strobes derive from the next state so they move on the same edge as the FSM.
  assign level_d = (state_d == STABLE_HI) || (state_d == CHK_LO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      if (glitch_inc && (glitch_q != 8'hFF)) begin
        glitch_q <= glitch_q + 8'd1;
      end
    end
  end

  assign bus.level_o      = level_q;
  assign bus.rise_o       = rise_q;
  assign bus.fall_o       = fall_q;
  assign bus.glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: default build (2 sync, 4 debounce) and a
// degenerate build (3 sync, 1 debounce). Expected strobes are queued when stimulus is driven.
module tb_input_conditioner;

  localparam int LAT  = 6;
  localparam int LAT2 = 4;

  typedef struct {
    bit rise;
    int cyc;
    bit lvl;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc      = 0;
  int   errors   = 0;
  int   checks   = 0;
  int   both_cnt = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t exp2_q[$];
  ev_t obs2_q[$];
  ev_t mon_e;

  input_conditioner_if bus();
  input_conditioner_if bus2();

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rise_o || bus.fall_o) begin
      mon_e.rise = bus.rise_o;
      mon_e.cyc  = cyc;
      mon_e.lvl  = bus.level_o;
      obs_q.push_back(mon_e);
    end
    if (bus2.rise_o || bus2.fall_o) begin
      mon_e.rise = bus2.rise_o;
      mon_e.cyc  = cyc;
      mon_e.lvl  = bus2.level_o;
      obs2_q.push_back(mon_e);
    end
    if (bus.rise_o && bus.fall_o) both_cnt++;
    if (bus2.rise_o && bus2.fall_o) both_cnt++;
  end

  function automatic ev_t mk(bit r, int c);
    ev_t e;
    e.rise = r;
    e.cyc  = c;
    e.lvl  = r;
    return e;
  endfunction

  // Inputs change 1 time unit after a rising edge, so no sample ever sees a setup
  // violation and the latency is exact.
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.async_i  = 1'b0;
    bus2.async_i = 1'b0;
    step(3);
    reset = 1'b1;
    step(6);
    exp_q.delete();
    obs_q.delete();
    exp2_q.delete();
    obs2_q.delete();
  endtask

  task automatic test_reset();
    ev_t e, o;
    int  k;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.async_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.level_o, bus.rise_o, bus.fall_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got level/rise/fall=%b, expected 000",
               {bus.level_o, bus.rise_o, bus.fall_o});
    end
    checks++;
    if (bus.glitch_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_glitch: got %0d, expected 0", bus.glitch_cnt_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    k = cyc;
    exp_q.push_back(mk(1'b1, k + LAT));
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL reset_event: got none, expected rise=%0b at cycle %0d", e.rise, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.rise !== e.rise || o.cyc !== e.cyc || o.lvl !== e.lvl) begin
          errors++;
          $display("FAIL reset_event: got rise=%0b cycle=%0d level=%0b, expected rise=%0b cycle=%0d level=%0b",
                   o.rise, o.cyc, o.lvl, e.rise, e.cyc, e.lvl);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
    checks++;
    if (bus.level_o !== 1'b1 || bus.glitch_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL reset_after: got level=%b glitch=%0d, expected level=1 glitch=0",
               bus.level_o, bus.glitch_cnt_o);
    end
  endtask

  task automatic test_toggle();
    ev_t e, o;
    int  k;
    do_reset();
    bus.async_i = 1'b1;
    k = cyc;
    exp_q.push_back(mk(1'b1, k + LAT));
    step(20);
    bus.async_i = 1'b0;
    k = cyc;
    exp_q.push_back(mk(1'b0, k + LAT));
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL toggle_event: got none, expected rise=%0b at cycle %0d", e.rise, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.rise !== e.rise || o.cyc !== e.cyc || o.lvl !== e.lvl) begin
          errors++;
          $display("FAIL toggle_event: got rise=%0b cycle=%0d level=%0b, expected rise=%0b cycle=%0d level=%0b",
                   o.rise, o.cyc, o.lvl, e.rise, e.cyc, e.lvl);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL toggle_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
    checks++;
    if (bus.level_o !== 1'b0 || bus.glitch_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL toggle_after: got level=%b glitch=%0d, expected level=0 glitch=0",
               bus.level_o, bus.glitch_cnt_o);
    end
  endtask

  task automatic test_bounce();
    ev_t e, o;
    int  k;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.async_i = 1'b1;
      step(2);
      bus.async_i = 1'b0;
      step(1);
    end
    bus.async_i = 1'b1;
    k = cyc;
    exp_q.push_back(mk(1'b1, k + LAT));
    step(12);
    checks++;
    if (bus.glitch_cnt_o !== 8'd3) begin
      errors++;
      $display("FAIL bounce_glitch: got %0d, expected 3", bus.glitch_cnt_o);
    end
    // a short low dip while high must be rejected by the mirrored check state
    bus.async_i = 1'b0;
    step(2);
    bus.async_i = 1'b1;
    step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL bounce_event: got none, expected rise=%0b at cycle %0d", e.rise, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.rise !== e.rise || o.cyc !== e.cyc || o.lvl !== e.lvl) begin
          errors++;
          $display("FAIL bounce_event: got rise=%0b cycle=%0d level=%0b, expected rise=%0b cycle=%0d level=%0b",
                   o.rise, o.cyc, o.lvl, e.rise, e.cyc, e.lvl);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
    checks++;
    if (bus.level_o !== 1'b1 || bus.glitch_cnt_o !== 8'd4) begin
      errors++;
      $display("FAIL bounce_dip: got level=%b glitch=%0d, expected level=1 glitch=4",
               bus.level_o, bus.glitch_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.async_i = 1'b1;
    step(4);
    checks++;
    if (bus.level_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: got level=%b, expected 0", bus.level_o);
    end
    #2;
    reset = 1'b0;
    bus.async_i = 1'b0;
    #1;
    checks++;
    if ({bus.level_o, bus.rise_o, bus.fall_o} !== 3'b000 || bus.glitch_cnt_o !== 8'd0) begin
      errors++;
      $display("FAIL midrst_async: got level/rise/fall=%b glitch=%0d, expected 000 and 0",
               {bus.level_o, bus.rise_o, bus.fall_o}, bus.glitch_cnt_o);
    end
    step(2);
    reset = 1'b1;
    step(10);
    checks++;
    if (bus.level_o !== 1'b0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_after: got level=%b pulses=%0d, expected level=0 pulses=0",
               bus.level_o, obs_q.size());
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 100; i++) begin
      bus.async_i = 1'b1;
      step(1);
      bus.async_i = 1'b0;
      step(1);
    end
    step(5);
    checks++;
    if (bus.glitch_cnt_o !== 8'd100) begin
      errors++;
      $display("FAIL sat_100: got %0d, expected 100", bus.glitch_cnt_o);
    end
    for (int i = 0; i < 155; i++) begin
      bus.async_i = 1'b1;
      step(1);
      bus.async_i = 1'b0;
      step(1);
    end
    step(5);
    checks++;
    if (bus.glitch_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL sat_255: got %0d, expected 255", bus.glitch_cnt_o);
    end
    for (int i = 0; i < 45; i++) begin
      bus.async_i = 1'b1;
      step(1);
      bus.async_i = 1'b0;
      step(1);
    end
    step(5);
    checks++;
    if (bus.glitch_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: got %0d, expected 255", bus.glitch_cnt_o);
    end
    checks++;
    if (bus.level_o !== 1'b0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL sat_level: got level=%b pulses=%0d, expected level=0 pulses=0",
               bus.level_o, obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    int  k;
    do_reset();
    bus.async_i = 1'b1;
    step(3);
    bus.async_i = 1'b0;
    step(8);
    checks++;
    if (bus.glitch_cnt_o !== 8'd1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_short: got glitch=%0d pulses=%0d, expected glitch=1 pulses=0",
               bus.glitch_cnt_o, obs_q.size());
    end
    bus.async_i = 1'b1;
    k = cyc;
    exp_q.push_back(mk(1'b1, k + LAT));
    step(4);
    bus.async_i = 1'b0;
    exp_q.push_back(mk(1'b0, k + 4 + LAT));
    step(12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_event: got none, expected rise=%0b at cycle %0d", e.rise, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.rise !== e.rise || o.cyc !== e.cyc || o.lvl !== e.lvl) begin
          errors++;
          $display("FAIL b2b_event: got rise=%0b cycle=%0d level=%0b, expected rise=%0b cycle=%0d level=%0b",
                   o.rise, o.cyc, o.lvl, e.rise, e.cyc, e.lvl);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0 || bus.glitch_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL b2b_after: got extra=%0d glitch=%0d, expected extra=0 glitch=1",
               obs_q.size(), bus.glitch_cnt_o);
    end
  endtask

  task automatic test_degenerate();
    ev_t e, o;
    int  k;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus2.async_i = (i % 2 == 0);
      k = cyc;
      exp2_q.push_back(mk(i % 2 == 0, k + LAT2));
      step(5);
    end
    step(8);
    while (exp2_q.size() > 0) begin
      e = exp2_q.pop_front();
      checks++;
      if (obs2_q.size() == 0) begin
        errors++;
        $display("FAIL degen_event: got none, expected rise=%0b at cycle %0d", e.rise, e.cyc);
      end else begin
        o = obs2_q.pop_front();
        if (o.rise !== e.rise || o.cyc !== e.cyc || o.lvl !== e.lvl) begin
          errors++;
          $display("FAIL degen_event: got rise=%0b cycle=%0d level=%0b, expected rise=%0b cycle=%0d level=%0b",
                   o.rise, o.cyc, o.lvl, e.rise, e.cyc, e.lvl);
        end
      end
    end
    checks++;
    if (obs2_q.size() != 0) begin
      errors++;
      $display("FAIL degen_extra: got %0d extra pulses, expected 0", obs2_q.size());
    end
    checks++;
    if (bus2.glitch_cnt_o !== 8'd0 || bus2.level_o !== 1'b0) begin
      errors++;
      $display("FAIL degen_after: got glitch=%0d level=%b, expected glitch=0 level=0",
               bus2.glitch_cnt_o, bus2.level_o);
    end
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL both_pulses: got %0d cycles with rise and fall, expected 0", both_cnt);
    end
  endtask

  initial begin
    bus.async_i  = 1'b0;
    bus2.async_i = 1'b0;
    test_reset();
    test_toggle();
    test_bounce();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    test_degenerate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
